// File: rtl/spio_spinnaker_link_rx_symbol.sv
// Purpose: decodes 2-of-7 NRZ link symbols, returns the NRZ ack and assembles 40/72-bit packets.
// Latency: a symbol completing at edge k gives an ack toggle at k+1; EOP gives PKT_VLD_OUT at k+1.
// Backpressure: single-entry output buffer; a completed packet that finds it stuck waits in HOLD with ack withheld.
//
// Ports:
//   CLK_IN, RESET_N_IN         clock, asynchronous active-low reset
//   SL_DATA_IN / SL_ACK_OUT    synchronized 2-of-7 link wires and returned NRZ acknowledge
//   PKT_DATA_OUT/_VLD/_RDY     assembled packet, valid/ready handshake (short packets use [39:0])
//   ERR_SYM_OUT, ERR_EOP_OUT   one-cycle error pulses: illegal symbol, framing error
// Build option: define SPIO_SL_RX_PARITY_CHECK_EN to drop packets with even parity;
//   this also adds the ERR_PAR_OUT pulse port.
module spio_spinnaker_link_rx_symbol (
    input  logic        CLK_IN,
    input  logic        RESET_N_IN,
    input  logic [6:0]  SL_DATA_IN,
    output logic        SL_ACK_OUT,
    output logic [71:0] PKT_DATA_OUT,
    output logic        PKT_VLD_OUT,
    input  logic        PKT_RDY_IN,
`ifdef SPIO_SL_RX_PARITY_CHECK_EN
    output logic        ERR_PAR_OUT,
`endif
    output logic        ERR_SYM_OUT,
    output logic        ERR_EOP_OUT
);

    typedef enum logic {RECV = 1'b0, HOLD = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [6:0]  last_q;
    logic [6:0]  diff;
    logic [2:0]  pop;
    logic        code_ok, code_eop;
    logic [3:0]  code_nib;
    logic [4:0]  n_q;
    logic [71:0] asm_q;
    logic [4:0]  exp_len;
    logic        sym_done, len_hit, frame_err, buf_busy, par_bad;
    logic        ack_tgl, pkt_load, asm_clr, asm_store, err_sym_d, err_eop_d;
`ifdef SPIO_SL_RX_PARITY_CHECK_EN
    logic        err_par_d;
`endif

    // Wires that changed since the last accepted symbol.
    assign diff = SL_DATA_IN ^ last_q;

    always_comb begin
        pop = '0;
        for (int i = 0; i < 7; i++) pop = pop + {2'b00, diff[i]};
    end

    // 2-of-7 code table; anything not listed (including every >2-hot value) is illegal.
    always_comb begin
        code_ok  = 1'b1;
        code_eop = 1'b0;
        code_nib = 4'h0;
        case (diff)
            7'h11: code_nib = 4'h0;
            7'h12: code_nib = 4'h1;
            7'h14: code_nib = 4'h2;
            7'h18: code_nib = 4'h3;
            7'h21: code_nib = 4'h4;
            7'h22: code_nib = 4'h5;
            7'h24: code_nib = 4'h6;
            7'h28: code_nib = 4'h7;
            7'h41: code_nib = 4'h8;
            7'h42: code_nib = 4'h9;
            7'h44: code_nib = 4'hA;
            7'h48: code_nib = 4'hB;
            7'h03: code_nib = 4'hC;
            7'h0C: code_nib = 4'hD;
            7'h30: code_nib = 4'hE;
            7'h60: code_nib = 4'hF;
            7'h50: code_eop = 1'b1;
            default: code_ok = 1'b0;
        endcase
    end

    // Fewer than two changed wires is a symbol still in flight.
    assign sym_done = (pop >= 3'd2);
    // Header bit 1 (payload flag) sits in asm_q once nibble 0 has been stored.
    assign exp_len  = asm_q[1] ? 5'd18 : 5'd10;
    assign len_hit  = (n_q == exp_len);
    // EOP must land exactly on the expected length; data must not arrive past it.
    assign frame_err = code_eop ? ~len_hit : len_hit;
    assign buf_busy  = PKT_VLD_OUT & ~PKT_RDY_IN;

`ifdef SPIO_SL_RX_PARITY_CHECK_EN
    // Unused upper bits of a short packet are zero, so one XOR covers both lengths.
    assign par_bad = ~^asm_q;
`else
    assign par_bad = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) state_q <= RECV;
        else             state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RECV: if (sym_done && code_ok && code_eop && len_hit && !par_bad && buf_busy)
                      state_d = HOLD;
            HOLD: if (!buf_busy) state_d = RECV;
            default: state_d = RECV;
        endcase
    end

    // Output/control decode.
    always_comb begin
        ack_tgl   = 1'b0;
        pkt_load  = 1'b0;
        asm_clr   = 1'b0;
        asm_store = 1'b0;
        err_sym_d = 1'b0;
        err_eop_d = 1'b0;
`ifdef SPIO_SL_RX_PARITY_CHECK_EN
        err_par_d = 1'b0;
`endif
        case (state_q)
            RECV: begin
                if (sym_done) begin
                    if (!code_ok) begin
                        ack_tgl = 1'b1; asm_clr = 1'b1; err_sym_d = 1'b1;
                    end else if (frame_err) begin
                        ack_tgl = 1'b1; asm_clr = 1'b1; err_eop_d = 1'b1;
                    end else if (!code_eop) begin
                        ack_tgl = 1'b1; asm_store = 1'b1;
                    end else if (par_bad) begin
                        ack_tgl = 1'b1; asm_clr = 1'b1;
`ifdef SPIO_SL_RX_PARITY_CHECK_EN
                        err_par_d = 1'b1;
`endif
                    end else if (!buf_busy) begin
                        ack_tgl = 1'b1; asm_clr = 1'b1; pkt_load = 1'b1;
                    end
                end
            end
            // The EOP stays on the wires while parked, so ack and last move only on release.
            HOLD: begin
                if (!buf_busy) begin
                    ack_tgl = 1'b1; asm_clr = 1'b1; pkt_load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath.
    always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            last_q       <= '0;
            SL_ACK_OUT   <= 1'b0;
            n_q          <= '0;
            asm_q        <= '0;
            PKT_DATA_OUT <= '0;
            PKT_VLD_OUT  <= 1'b0;
            ERR_SYM_OUT  <= 1'b0;
            ERR_EOP_OUT  <= 1'b0;
`ifdef SPIO_SL_RX_PARITY_CHECK_EN
            ERR_PAR_OUT  <= 1'b0;
`endif
        end else begin
            ERR_SYM_OUT <= err_sym_d;
            ERR_EOP_OUT <= err_eop_d;
`ifdef SPIO_SL_RX_PARITY_CHECK_EN
            ERR_PAR_OUT <= err_par_d;
`endif
            if (ack_tgl) begin
                SL_ACK_OUT <= ~SL_ACK_OUT;
                last_q     <= SL_DATA_IN;
            end
            if (asm_clr) begin
                asm_q <= '0;
                n_q   <= '0;
            end else if (asm_store) begin
                // Least-significant nibble first: nibble n lands at bits [4n+3:4n].
                asm_q <= asm_q | ({68'd0, code_nib} << {n_q, 2'b00});
                n_q   <= n_q + 5'd1;
            end
            // Load wins over drain so a same-cycle drain-and-load keeps VLD high.
            if (pkt_load) begin
                PKT_DATA_OUT <= asm_q;
                PKT_VLD_OUT  <= 1'b1;
            end else if (PKT_RDY_IN) begin
                PKT_VLD_OUT  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spio_spinnaker_link_rx_symbol.sv
module tb_spio_spinnaker_link_rx_symbol;

    logic        CLK_IN = 1'b0;
    logic        RESET_N_IN = 1'b0;
    logic [6:0]  SL_DATA_IN = 7'h00;
    logic        SL_ACK_OUT;
    logic [71:0] PKT_DATA_OUT;
    logic        PKT_VLD_OUT;
    logic        PKT_RDY_IN = 1'b1;
    logic        ERR_SYM_OUT;
    logic        ERR_EOP_OUT;
`ifdef SPIO_SL_RX_PARITY_CHECK_EN
    logic        ERR_PAR_OUT;
`endif

    always #5 CLK_IN = ~CLK_IN;

    spio_spinnaker_link_rx_symbol dut (
        .CLK_IN       (CLK_IN),
        .RESET_N_IN   (RESET_N_IN),
        .SL_DATA_IN   (SL_DATA_IN),
        .SL_ACK_OUT   (SL_ACK_OUT),
        .PKT_DATA_OUT (PKT_DATA_OUT),
        .PKT_VLD_OUT  (PKT_VLD_OUT),
        .PKT_RDY_IN   (PKT_RDY_IN),
`ifdef SPIO_SL_RX_PARITY_CHECK_EN
        .ERR_PAR_OUT  (ERR_PAR_OUT),
`endif
        .ERR_SYM_OUT  (ERR_SYM_OUT),
        .ERR_EOP_OUT  (ERR_EOP_OUT)
    );

    int          checks = 0;
    int          errors = 0;
    logic [71:0] exp_q[$];
    int          sym_sent = 0, ack_seen = 0;
    int          exp_sym = 0, seen_sym = 0;
    int          exp_eop = 0, seen_eop = 0;
    int          exp_par = 0, seen_par = 0;
    logic        prev_ack = 1'b0;
    logic        ack_ref = 1'b0;
    bit          rdy_mode = 1'b0;   // 1: random ready
    bit          rdy_force = 1'b1;  // ready level when not random

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Symbol 0..15 = data nibble, 16 = EOP.
    function automatic logic [6:0] code_of(input int sym);
        case (sym)
            0:  return 7'h11;  1:  return 7'h12;  2:  return 7'h14;  3:  return 7'h18;
            4:  return 7'h21;  5:  return 7'h22;  6:  return 7'h24;  7:  return 7'h28;
            8:  return 7'h41;  9:  return 7'h42;  10: return 7'h44;  11: return 7'h48;
            12: return 7'h03;  13: return 7'h0C;  14: return 7'h30;  15: return 7'h60;
            default: return 7'h50;
        endcase
    endfunction

    // Flip the wires of one symbol; with gap>0 a 2-hot code arrives one wire at a time.
    task automatic drive_sym(input logic [6:0] code, input int gap);
        logic [6:0] first;
        first = code & (~code + 7'd1);
        @(posedge CLK_IN); #1;
        ack_ref = SL_ACK_OUT;
        if (gap > 0 && $countones(code) == 2) begin
            SL_DATA_IN = SL_DATA_IN ^ first;
            repeat (gap) begin @(posedge CLK_IN); #1; end
            chk("partial_no_ack", SL_ACK_OUT, ack_ref);
            SL_DATA_IN = SL_DATA_IN ^ code ^ first;
        end else begin
            SL_DATA_IN = SL_DATA_IN ^ code;
        end
        sym_sent++;
    endtask

    task automatic wait_ack(input bit fast, input string name);
        int cyc;
        cyc = 0;
        while (SL_ACK_OUT === ack_ref && cyc < 400) begin
            @(posedge CLK_IN); #1;
            cyc++;
        end
        if (SL_ACK_OUT === ack_ref) begin
            checks++; errors++;
            $display("FAIL %s ack_timeout actual=none required=toggle", name);
        end else if (fast) begin
            chk(name, cyc, 1);
        end
    endtask

    task automatic send_sym(input logic [6:0] code, input int gap, input bit fast, input string name);
        drive_sym(code, gap);
        wait_ack(fast, name);
    endtask

    // Model: a frame whose length equals the header's expected length is the packet v itself;
    // any shorter frame closed by EOP is a framing error.
    task automatic send_frame(input logic [71:0] v, input int len, input int gap,
                              input bit eop_fast, input bit good);
        int g;
        for (int i = 0; i < len; i++) begin
            g = (gap >= 0) ? gap : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            send_sym(code_of(int'(v[4*i +: 4])), g, 1'b1, "nib_ack_lat");
        end
        if (good) begin
`ifdef SPIO_SL_RX_PARITY_CHECK_EN
            if (^v) exp_q.push_back(v);
            else    exp_par++;
`else
            exp_q.push_back(v);
`endif
        end else begin
            exp_eop++;
        end
        send_sym(code_of(16), 0, eop_fast, "eop_ack_lat");
    endtask

    task automatic send_badsym(input logic [71:0] v, input int pos, input logic [6:0] bad);
        for (int i = 0; i < pos; i++)
            send_sym(code_of(int'(v[4*i +: 4])), 0, 1'b1, "nib_ack_lat");
        exp_sym++;
        send_sym(bad, 0, 1'b1, "badsym_ack_lat");
    endtask

    // Ready driver: applied a little after the edge, after the symbol driver.
    initial forever begin
        @(posedge CLK_IN); #2;
        PKT_RDY_IN = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    // Monitor / scoreboard.
    initial forever begin
        @(negedge CLK_IN);
        if (!RESET_N_IN) begin
            prev_ack = SL_ACK_OUT;
        end else begin
            if (ERR_SYM_OUT) begin
                seen_sym++;
                chk("err_sym_with_ack", SL_ACK_OUT ^ prev_ack, 1);
            end
            if (ERR_EOP_OUT) begin
                seen_eop++;
                chk("err_eop_with_ack", SL_ACK_OUT ^ prev_ack, 1);
            end
`ifdef SPIO_SL_RX_PARITY_CHECK_EN
            if (ERR_PAR_OUT) begin
                seen_par++;
                chk("err_par_with_ack", SL_ACK_OUT ^ prev_ack, 1);
            end
`endif
            if (SL_ACK_OUT !== prev_ack) ack_seen++;
            prev_ack = SL_ACK_OUT;
            if (PKT_VLD_OUT && PKT_RDY_IN) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pkt_unexpected actual=%0h required=none", PKT_DATA_OUT);
                end else begin
                    chk("pkt_data", PKT_DATA_OUT, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int          t0, kind, len;
        logic [71:0] v, va, vb;
        logic [6:0]  bad;
        logic [6:0]  ill2 [4];
        ill2 = '{7'h05, 7'h06, 7'h09, 7'h0A};

        // Reset values.
        repeat (3) @(negedge CLK_IN);
        chk("rst_ack", SL_ACK_OUT, 0);
        chk("rst_vld", PKT_VLD_OUT, 0);
        chk("rst_data", PKT_DATA_OUT, 0);
        chk("rst_err_sym", ERR_SYM_OUT, 0);
        chk("rst_err_eop", ERR_EOP_OUT, 0);
        @(posedge CLK_IN); #1;
        RESET_N_IN = 1'b1;

        // Short packet: header 0x00, key 0x12345678.
        t0 = ack_seen;
        send_frame(72'h0000_0000_1234_5678_00, 10, 0, 1'b1, 1'b1);
        @(negedge CLK_IN);
        chk("short_ack_count", ack_seen - t0, 11);

        // Long packet: header 0x02, key 0xDEADBEEF, payload 0xCAFEF00D.
        t0 = ack_seen;
        send_frame(72'hCAFEF00D_DEADBEEF_02, 18, 0, 1'b1, 1'b1);
        @(negedge CLK_IN);
        chk("long_ack_count", ack_seen - t0, 19);

        // Backpressure: second EOP parks until the buffer drains.
        rdy_force = 1'b0;
        repeat (2) @(posedge CLK_IN);
        va = {32'h0, 32'hA5A5_0001, 8'h00};
        vb = {32'h0, 32'h5A5A_0002, 8'h00};
        send_frame(va, 10, 0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++)
            send_sym(code_of(int'(vb[4*i +: 4])), 0, 1'b1, "nib_ack_lat");
        exp_q.push_back(vb);
        drive_sym(code_of(16), 0);
        repeat (6) begin @(posedge CLK_IN); #1; end
        chk("hold_ack_withheld", SL_ACK_OUT, ack_ref);
        chk("hold_buf_vld", PKT_VLD_OUT, 1);
        chk("hold_buf_data", PKT_DATA_OUT, va);
        rdy_force = 1'b1;
        wait_ack(1'b1, "hold_release_ack_lat");
        repeat (3) @(posedge CLK_IN);

        // Errors: 3-wire change, illegal 2-hot, early EOP, overlong packet.
        send_badsym(72'h0000_0000_1111_2222_00, 3, 7'h07);
        send_badsym(72'h0000_0000_3333_4444_00, 0, 7'h05);
        @(negedge CLK_IN);
        chk("err_sym_count", seen_sym, exp_sym);
        send_frame(72'h0000_0000_9876_5432_00, 5, 0, 1'b1, 1'b0);
        @(negedge CLK_IN);
        chk("err_eop_count", seen_eop, exp_eop);
        chk("no_vld_after_eop_err", PKT_VLD_OUT, 0);
        v = 72'h0000_0000_1357_2468_00;
        for (int i = 0; i < 11; i++)
            send_sym(code_of(int'(v[4*i +: 4])), 0, 1'b1, "nib_ack_lat");
        exp_eop += 2;   // data past the length, then an EOP on an empty frame
        send_sym(code_of(16), 0, 1'b1, "eop_ack_lat");
        @(negedge CLK_IN);
        chk("overlong_eop_count", seen_eop, exp_eop);
        send_frame(72'h0000_0000_1234_5678_00, 10, 0, 1'b1, 1'b1);

        // Staggered wires: each nibble's second wire arrives 4 cycles after the first.
        send_frame({32'h0, 32'h7654_3211, 8'h00}, 10, 4, 1'b1, 1'b1);

        // Reset mid-packet.
        v = {32'h0, 32'h0BAD_CAFE, 8'h00};
        for (int i = 0; i < 4; i++)
            send_sym(code_of(int'(v[4*i +: 4])), 0, 1'b1, "nib_ack_lat");
        @(posedge CLK_IN); #1;
        RESET_N_IN = 1'b0;
        SL_DATA_IN = 7'h00;
        #1;
        chk("midrst_ack", SL_ACK_OUT, 0);
        chk("midrst_vld", PKT_VLD_OUT, 0);
        chk("midrst_data", PKT_DATA_OUT, 0);
        chk("midrst_err_sym", ERR_SYM_OUT, 0);
        chk("midrst_err_eop", ERR_EOP_OUT, 0);
        exp_q.delete();
        repeat (3) begin @(posedge CLK_IN); #1; end
        RESET_N_IN = 1'b1;
        send_frame(v, 10, 0, 1'b1, 1'b1);

`ifdef SPIO_SL_RX_PARITY_CHECK_EN
        // Even-parity packet is dropped with ERR_PAR_OUT.
        send_frame({32'h0, 32'h0000_0011, 8'h00}, 10, 0, 1'b1, 1'b1);
        @(negedge CLK_IN);
        chk("par_err_count", seen_par, exp_par);
`endif

        // Random frames with random ready.
        rdy_mode = 1'b1;
        for (int f = 0; f < 60; f++) begin
            kind = int'($urandom_range(0, 9));
            v[31:0]  = $urandom;
            v[63:32] = $urandom;
            v[71:64] = 8'($urandom);
            len = v[1] ? 18 : 10;
            if (!v[1]) v[71:40] = '0;
            if (kind < 7) begin
                send_frame(v, len, -1, 1'b0, 1'b1);
            end else if (kind < 9) begin
                send_frame(v, int'($urandom_range(0, len - 1)), -1, 1'b1, 1'b0);
            end else begin
                bad = 7'($urandom_range(0, 127));
                if ($countones(bad) < 3) bad = ill2[$urandom_range(0, 3)];
                send_badsym(v, int'($urandom_range(0, len - 1)), bad);
            end
        end

        // Drain and final tallies.
        rdy_mode = 1'b0;
        rdy_force = 1'b1;
        repeat (20) @(posedge CLK_IN);
        @(negedge CLK_IN);
        chk("pkts_outstanding", exp_q.size(), 0);
        chk("final_err_sym", seen_sym, exp_sym);
        chk("final_err_eop", seen_eop, exp_eop);
        chk("final_err_par", seen_par, exp_par);
        chk("final_ack_toggles", ack_seen, sym_sent);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
